// File: rtl/mor1kx_icache_refill_wb.sv
// Instruction-cache refill master for Wishbone B3.
// On a refill request it fetches one cache line, critical word first, with a
// wrapping burst. Each returned word is forwarded into the cache in the same
// cycle it is acknowledged.
//
// Handshake: a Wishbone beat completes on any cycle where cyc & stb are high and
// the slave raises ack or err. Err wins over ack. While neither is seen, stb
// and the address are held. The cache write strobe we_o is valid only in such a
// completing cycle and takes no ready back from the cache.
module mor1kx_icache_refill_wb #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    input  logic                            refill_done_i,

    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            busy_o,
    output logic                            bus_err_o,

    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i
);

    localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int OFFW  = BW - 2;

    localparam logic [OFFW-1:0] LAST_BEAT = '1;
    localparam logic [1:0]      BURST_BTE = (BW == 5) ? 2'b10 : 2'b01;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]                      state;
    logic [1:0]                      state_next;
    logic [OPTION_OPERAND_WIDTH-1:0] adr;
    logic [OFFW-1:0]                 beat_cnt;

    logic in_burst;
    logic last_beat;
    logic beat_ok;

    assign in_burst  = (state == BURST);
    assign last_beat = (beat_cnt == LAST_BEAT);
    // A beat that actually delivers data: error cancels a simultaneous ack.
    assign beat_ok   = in_burst & wbm_ack_i & ~wbm_err_i;

    // Next-state selection; GAP always spends one cycle so a stale request
    // cannot restart a burst back to back.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (refill_req_i) state_next = BURST;
            BURST: begin
                if (wbm_err_i)                   state_next = GAP;
                else if (wbm_ack_i && last_beat) state_next = GAP;
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, line address and beat counter; the offset bits wrap inside the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            adr      <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && refill_req_i) begin
                adr      <= refill_adr_i & ~OPTION_OPERAND_WIDTH'(3);
                beat_cnt <= '0;
            end else if (beat_ok) begin
                adr[BW-1:2] <= adr[BW-1:2] + 1'b1;
                beat_cnt    <= beat_cnt + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // The cache must agree that the final beat of the line completes it.
    always_ff @(posedge clk) begin
        if (!rst && beat_ok && last_beat)
            assert (refill_done_i);
    end
`endif

    assign wbm_adr_o = adr;
    assign wbm_cyc_o = in_burst;
    assign wbm_stb_o = in_burst;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hf;
    assign wbm_cti_o = !in_burst ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    assign wbm_bte_o = BURST_BTE;

    assign we_o      = beat_ok;
    assign wradr_o   = adr;
    assign wrdat_o   = wbm_dat_i;
    assign busy_o    = (state != IDLE);
    assign bus_err_o = in_burst & wbm_err_i;

endmodule

// File: tb/tb_mor1kx_icache_refill_wb.sv
// Bench for the icache refill master: one 8-beat and one 4-beat instance share
// the stimulus; only the selected one sees request/ack/err.
module tb_mor1kx_icache_refill_wb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, sel5, done, ack, err;
    logic [31:0] req_adr, dat;

    logic [31:0] wradr5, wrdat5, wadr5, wradr4, wrdat4, wadr4;
    logic        we5, busy5, berr5, cyc5, stb5, wwe5;
    logic        we4, busy4, berr4, cyc4, stb4, wwe4;
    logic [3:0]  wsel5, wsel4;
    logic [2:0]  cti5, cti4;
    logic [1:0]  bte5, bte4;

    mor1kx_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) u_dut5 (
        .clk(clk), .rst(rst),
        .refill_req_i(req & sel5), .refill_adr_i(req_adr), .refill_done_i(done & sel5),
        .wradr_o(wradr5), .wrdat_o(wrdat5), .we_o(we5), .busy_o(busy5), .bus_err_o(berr5),
        .wbm_adr_o(wadr5), .wbm_cyc_o(cyc5), .wbm_stb_o(stb5), .wbm_we_o(wwe5),
        .wbm_sel_o(wsel5), .wbm_cti_o(cti5), .wbm_bte_o(bte5),
        .wbm_dat_i(dat), .wbm_ack_i(ack & sel5), .wbm_err_i(err & sel5)
    );

    mor1kx_icache_refill_wb #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .refill_req_i(req & ~sel5), .refill_adr_i(req_adr), .refill_done_i(done & ~sel5),
        .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4), .busy_o(busy4), .bus_err_o(berr4),
        .wbm_adr_o(wadr4), .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(wwe4),
        .wbm_sel_o(wsel4), .wbm_cti_o(cti4), .wbm_bte_o(bte4),
        .wbm_dat_i(dat), .wbm_ack_i(ack & ~sel5), .wbm_err_i(err & ~sel5)
    );

    // Observed outputs of whichever instance is selected.
    logic [31:0] o_wradr, o_wrdat, o_adr;
    logic        o_we, o_busy, o_berr, o_cyc, o_stb, o_wwe;
    logic [3:0]  o_sel;
    logic [2:0]  o_cti;
    logic [1:0]  o_bte;
    assign o_wradr = sel5 ? wradr5 : wradr4;
    assign o_wrdat = sel5 ? wrdat5 : wrdat4;
    assign o_adr   = sel5 ? wadr5  : wadr4;
    assign o_we    = sel5 ? we5    : we4;
    assign o_busy  = sel5 ? busy5  : busy4;
    assign o_berr  = sel5 ? berr5  : berr4;
    assign o_cyc   = sel5 ? cyc5   : cyc4;
    assign o_stb   = sel5 ? stb5   : stb4;
    assign o_wwe   = sel5 ? wwe5   : wwe4;
    assign o_sel   = sel5 ? wsel5  : wsel4;
    assign o_cti   = sel5 ? cti5   : cti4;
    assign o_bte   = sel5 ? bte5   : bte4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_we     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference address of beat k: the word offset wraps inside the aligned line.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int bw, input int k);
        logic [31:0] line_base, word;
        int beats;
        beats     = 1 << (bw - 2);
        line_base = a & ~((32'd1 << bw) - 32'd1);
        word      = ((a >> 2) + 32'(k)) % 32'(beats);
        return line_base | (word << 2);
    endfunction

    // One refill: request from IDLE, then beats with optional waits, error or reset.
    // waits < 0 picks 0..3 wait states per beat at random.
    task automatic run_burst(input bit use5, input logic [31:0] a, input int waits,
                             input int err_beat, input int rst_beat, input bit hold);
        int bw, beats, nw, we_before;
        bit was_err, was_rst;
        logic [31:0] ea;
        bw        = use5 ? 5 : 4;
        beats     = 1 << (bw - 2);
        was_err   = 0;
        was_rst   = 0;
        we_before = n_we;

        @(negedge clk);
        sel5 = use5; req = 1'b1; req_adr = a;
        #1;
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_cyc",  32'(o_cyc),  32'd0);
        @(posedge clk);

        for (int k = 0; k < beats; k++) begin
            ea = beat_addr(a, bw, k);
            nw = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
            for (int w = 0; w < nw; w++) begin
                @(negedge clk);
                req = hold; ack = 1'b0; err = 1'b0; done = 1'b0;
                #1;
                check("wait_stb", 32'(o_stb), 32'd1);
                check("wait_adr", o_adr, ea);
                check("wait_we",  32'(o_we), 32'd0);
            end
            @(negedge clk);
            req  = hold;
            ack  = 1'b1;
            err  = (k == err_beat);
            rst  = (k == rst_beat);
            done = (k == beats - 1);
            dat  = $urandom;
            #1;
            check("beat_cyc",   32'(o_cyc), 32'd1);
            check("beat_adr",   o_adr, ea);
            check("beat_cti",   32'(o_cti), (k == beats - 1) ? 32'd7 : 32'd2);
            check("beat_bte",   32'(o_bte), use5 ? 32'd2 : 32'd1);
            check("beat_we",    32'(o_we), err ? 32'd0 : 32'd1);
            check("beat_berr",  32'(o_berr), err ? 32'd1 : 32'd0);
            check("beat_wwe",   32'(o_wwe), 32'd0);
            check("beat_sel",   32'(o_sel), 32'hf);
            if (!err) begin
                check("beat_wradr", o_wradr, ea);
                check("beat_wrdat", o_wrdat, dat);
                n_we++;
            end
            was_err = err;
            was_rst = rst;
            @(posedge clk);
            if (was_err || was_rst) break;
        end

        @(negedge clk);
        ack = 1'b0; err = 1'b0; done = 1'b0; rst = 1'b0;
        if (!hold) req = 1'b0;
        #1;
        if (was_rst) begin
            check("rst_cyc",  32'(o_cyc),  32'd0);
            check("rst_stb",  32'(o_stb),  32'd0);
            check("rst_busy", 32'(o_busy), 32'd0);
        end else begin
            check("gap_cyc",  32'(o_cyc),  32'd0);
            check("gap_busy", 32'(o_busy), 32'd1);
            check("gap_berr", 32'(o_berr), 32'd0);
            if (!was_err) check("we_count", 32'(n_we - we_before), 32'(beats));
        end
        check("post_we", 32'(o_we), 32'd0);
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; sel5 = 1'b1; done = 1'b0; ack = 1'b0; err = 1'b0;
        req_adr = '0; dat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cyc",  32'(o_cyc),  32'd0);
        check("rst_stb",  32'(o_stb),  32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_berr", 32'(o_berr), 32'd0);
        check("rst_we",   32'(o_we),   32'd0);
        check("rst_adr",  o_adr,       32'd0);
        rst = 1'b0;

        run_burst(1'b1, 32'h0000_1014, 0, -1, -1, 1'b0);
        run_burst(1'b0, 32'h0000_200C, 0, -1, -1, 1'b0);
        run_burst(1'b1, 32'h0000_5A28, 3, -1, -1, 1'b0);
        run_burst(1'b1, 32'h0000_3000, 0,  2, -1, 1'b0);
        run_burst(1'b1, 32'h0000_3454, 1, -1, -1, 1'b0);
        run_burst(1'b0, 32'h0000_2230, 0, -1, -1, 1'b1);
        run_burst(1'b0, 32'h0000_2244, 2, -1, -1, 1'b0);
        run_burst(1'b1, 32'h0000_4018, 0, -1,  3, 1'b0);
        run_burst(1'b1, 32'h0000_4018, 0, -1, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_burst(1'($urandom_range(0, 1)), $urandom, -1, -1, -1, 1'b0);
        end

        @(negedge clk);
        #1;
        check("end_busy", 32'(o_busy), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mor1kx_icache_refill_wb.md
Name: mor1kx_icache_refill_wb

Overview:
Wishbone B3 burst master that services instruction-cache misses. It sits directly downstream of the icache's refill request and upstream of its write port. On a refill request it fetches one full cache line, critical word first, using a wrapping burst. It streams each returned word into the cache through wradr/wrdat/we, with no added latency.

Parameters:
OPTION_OPERAND_WIDTH, 32, data/address width; only 32 is supported.
OPTION_ICACHE_BLOCK_WIDTH, 5, log2 of line size in bytes; only 4 (4 beats) or 5 (8 beats) are legal.

Ports:
clk  in  1  clock
rst  in  1  reset
refill_req_i  in  1  cache requests a line refill
refill_adr_i  in  32  miss address (word aligned; bits [1:0] ignored)
refill_done_i  in  1  cache reports the current write completes the line
wradr_o  out  32  address of the word being written into the cache
wrdat_o  out  32  instruction word being written
we_o  out  1  cache write strobe
busy_o  out  1  burst in progress (BURST or GAP state)
bus_err_o  out  1  one-cycle pulse on bus error; the refill is aborted
wbm_adr_o  out  32  Wishbone address
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  always 0
wbm_sel_o  out  4  always 4'hf
wbm_cti_o  out  3  cycle type identifier
wbm_bte_o  out  2  burst type extension
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  bus error

Behaviour:
- Reset: rst is synchronous, active-high, on clk. Reset forces state IDLE. While in reset, cyc, stb, we_o, busy_o and bus_err_o are 0, and the address and beat-counter registers are 0. Reset mid-burst drops cyc/stb at the next edge, with no further we_o.
- States: IDLE, BURST, GAP.
- IDLE:
  - If refill_req_i is asserted: latch adr = {refill_adr_i[31:2], 2'b00}, clear beat_cnt, go to BURST.
  - Otherwise stay in IDLE.
- BURST:
  - cyc = stb = 1; wbm_adr_o = adr.
  - wbm_bte_o = 2'b10 (8-beat wrap) when BLOCK_WIDTH=5, 2'b01 (4-beat wrap) when BLOCK_WIDTH=4.
  - wbm_cti_o = 3'b010, except 3'b111 when beat_cnt == BEATS-1.
  - BEATS = 2^(BLOCK_WIDTH-2).
- Write path (combinational, zero latency):
  - we_o = BURST & wbm_ack_i & !wbm_err_i.
  - wradr_o = adr.
  - wrdat_o = wbm_dat_i.
- Beat advance on each ack:
  - adr[BLOCK_WIDTH-1:2] increments modulo BEATS.
  - adr[31:BLOCK_WIDTH] is held.
  - beat_cnt increments.
- Completion: on the ack with beat_cnt == BEATS-1, go to GAP. refill_done_i is expected high in that same cycle; a mismatch is an assertion failure in simulation only.
- GAP: lasts one cycle with cyc = stb = 0 and refill_req_i ignored, then go to IDLE. This prevents a stale request from restarting a burst.
- Error:
  - wbm_err_i in BURST (including the same cycle as ack) suppresses we_o, pulses bus_err_o for one cycle, drops cyc/stb next cycle, and goes to GAP.
  - Err takes priority over ack.
  - wbm_err_i/ack_i outside BURST are ignored.
- Wait states: stb stays asserted and adr is held until ack or err; there is no timeout.
- refill_req_i deasserting mid-burst has no effect; a burst always runs to completion or error.
- busy_o = (state != IDLE).

Test Plan:
- BLOCK_WIDTH=5, refill_req_i with refill_adr_i=0x0000_1014, zero-wait slave -> wbm_adr_o sequence 0x1014, 0x1018, 0x101C, 0x1000, 0x1004, 0x1008, 0x100C, 0x1010; bte=2'b10; cti=010 ×7 then 111; 8 we_o pulses, wradr_o equal to each address, wrdat_o = slave data; then GAP, then IDLE.
- BLOCK_WIDTH=4, refill_adr_i=0x0000_200C -> addresses 0x200C, 0x2000, 0x2004, 0x2008; bte=2'b01; cti 111 on the 4th beat; busy_o falls 2 cycles after the last ack.
- Slave inserts 3 wait states per beat -> adr/stb stable during waits, exactly one we_o per ack, 8 total.
- wbm_err_i on the 3rd beat of adr 0x3000 (ack also high) -> no we_o that cycle, bus_err_o pulses once, cyc=0 the next cycle, IDLE after GAP; a new refill_req_i then starts a fresh burst at its own address.
- refill_req_i held high through a completed burst -> no second burst starts during GAP; a new burst starts only if refill_req_i is still high in IDLE.
- rst asserted on beat 4 -> cyc/stb/we_o = 0 on the next edge; the first post-reset request restarts the burst at its critical word.
